i2c_poll_sched: RTL

- Upstream sequencer for the WB-side I2C read controller. Periodically polls two fixed I2C slaves by pulsing the controller's start with a slave address, and waits for its done pulse.
- Captures each read byte, tagged with its slave address, into a small show-ahead result FIFO for a downstream consumer using a valid/ready handshake.
- Detects a hung controller with a timeout and latches a fault.

---
 rtl/i2c_poll_sched_if.sv | 25 ++
 rtl/i2c_poll_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_sched_if.sv
// Handshake bundle: controller start/done (ctl_*) and result stream (res_*).
interface i2c_poll_sched_if;
    logic       ctl_start;
    logic [6:0] ctl_slave_addr;
    logic       ctl_done;
    logic [7:0] ctl_rd_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [6:0] res_addr;

    modport master (
        output ctl_start, ctl_slave_addr,
        input  ctl_done, ctl_rd_data,
        output res_valid, res_data, res_addr,
        input  res_ready
    );

    modport slave (
        input  ctl_start, ctl_slave_addr,
        output ctl_done, ctl_rd_data,
        input  res_valid, res_data, res_addr,
        output res_ready
    );
endinterface

// File: rtl/i2c_poll_sched.sv
// Polls two I2C slaves round-robin, queues tagged bytes in a show-ahead FIFO, latches a timeout fault.
// Entry visible 2 cycles after ctl_done; full FIFO drops and sets overflow. Option: I2C_POLL_CHANGE_ONLY_EN.
module i2c_poll_sched #(
    parameter logic [31:0] POLL_PERIOD = 32'd50000,
    parameter logic [6:0]  SADDR0      = 7'h10,
    parameter logic [6:0]  SADDR1      = 7'h20,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    i2c_poll_sched_if.master            bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic                        fault,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_PUSH,
        S_WAIT_PERIOD,
        S_FAULT
    } state_t;

    state_t      state;
    logic        slv_idx;
    logic [31:0] tmo_cnt;
    logic [31:0] per_cnt;
    logic [7:0]  rd_byte;

    logic [7:0]  mem_data [FIFO_DEPTH];
    logic [6:0]  mem_addr [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic keep;
    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic drop;

`ifdef I2C_POLL_CHANGE_ONLY_EN
    logic [7:0] last_val [2];
    logic [1:0] seen;

    assign keep = !seen[slv_idx] || (rd_byte != last_val[slv_idx]);

    // History tracks every completed read, pushed or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val[0] <= 8'h00;
            last_val[1] <= 8'h00;
            seen        <= 2'b00;
        end else if (state == S_PUSH) begin
            last_val[slv_idx] <= rd_byte;
            seen[slv_idx]     <= 1'b1;
        end
    end
`else
    assign keep = 1'b1;
`endif

    assign push_req = (state == S_PUSH) && keep;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = (count != '0) && bus.res_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign bus.res_valid = (count != '0);
    assign bus.res_data  = mem_data[rd_ptr];
    assign bus.res_addr  = mem_addr[rd_ptr];
    assign fifo_count    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= 8'h00;
                mem_addr[i] <= 7'h00;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= rd_byte;
                mem_addr[wr_ptr] <= bus.ctl_slave_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Outputs are set on the transition into a state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            slv_idx            <= 1'b0;
            tmo_cnt            <= '0;
            per_cnt            <= '0;
            rd_byte            <= 8'h00;
            bus.ctl_start      <= 1'b0;
            bus.ctl_slave_addr <= 7'h00;
            busy               <= 1'b0;
            fault              <= 1'b0;
        end else begin
            bus.ctl_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        slv_idx            <= 1'b0;
                        state              <= S_ISSUE;
                        bus.ctl_start      <= 1'b1;
                        bus.ctl_slave_addr <= SADDR0;
                        busy               <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (bus.ctl_done) begin
                        rd_byte <= bus.ctl_rd_data;
                        state   <= S_PUSH;
                        busy    <= 1'b0;
                    end else if (tmo_cnt == TIMEOUT - 32'd1) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_PUSH: begin
                    if (!slv_idx && enable) begin
                        slv_idx            <= 1'b1;
                        state              <= S_ISSUE;
                        bus.ctl_start      <= 1'b1;
                        bus.ctl_slave_addr <= SADDR1;
                        busy               <= 1'b1;
                    end else begin
                        slv_idx <= 1'b0;
                        per_cnt <= '0;
                        state   <= enable ? S_WAIT_PERIOD : S_IDLE;
                    end
                end
                S_WAIT_PERIOD: begin
                    if (!enable) begin
                        per_cnt <= '0;
                        state   <= S_IDLE;
                    end else if (per_cnt == POLL_PERIOD - 32'd1) begin
                        per_cnt            <= '0;
                        state              <= S_ISSUE;
                        bus.ctl_start      <= 1'b1;
                        bus.ctl_slave_addr <= SADDR0;
                        busy               <= 1'b1;
                    end else begin
                        per_cnt <= per_cnt + 32'd1;
                    end
                end
                S_FAULT: begin
                    // The controller cannot be aborted, so only rst leaves here.
                    fault <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
